// File: rtl/iir_pkg.sv
// Shared constants and FSM state encoding for the first-order inverse IIR filter.
package iir_pkg;

  // Q-format description: Q1.15 samples, Q4.12 coefficients.
  localparam int FRAC_IN    = 15;
  localparam int FRAC_COEF  = 12;
  localparam int SAMPLE_W   = FRAC_IN + 1;
  localparam int ROUND_K    = 1 << (FRAC_COEF - 1);

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  // Three-step MAC sequence around a single shared multiplier.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/sat_round_shift.sv
// Combinational round-half-up, arithmetic shift by FRAC_COEF and 16-bit saturation.
module sat_round_shift
  import iir_pkg::*;
#(
  parameter int ACC_W = 36
) (
  input  logic signed [ACC_W-1:0]    i_acc,
  output logic signed [SAMPLE_W-1:0] o_data,
  output logic                       o_clamp
);

  localparam logic signed [ACC_W-1:0] K_ROUND = ACC_W'(ROUND_K);
  localparam logic signed [ACC_W-1:0] K_MAX   = ACC_W'(SAMPLE_MAX);
  localparam logic signed [ACC_W-1:0] K_MIN   = ACC_W'(SAMPLE_MIN);

  logic signed [ACC_W-1:0] w_rounded;
  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_over;
  logic                    w_under;

  // The accumulator is at least two bits wider than the worst-case sum, so the
  // rounding constant can be added without any chance of wrapping.
  assign w_rounded = i_acc + K_ROUND;
  assign w_shifted = w_rounded >>> FRAC_COEF;
  assign w_over    = (w_shifted > K_MAX);
  assign w_under   = (w_shifted < K_MIN);

  // Clamp to the Q1.15 range and flag when clamping happened.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    o_data  = w_shifted[SAMPLE_W-1:0];
    o_clamp = w_over | w_under;
    if (w_over) begin
      o_data = SAMPLE_W'(SAMPLE_MAX);
    end else if (w_under) begin
      o_data = SAMPLE_W'(SAMPLE_MIN);
    end
  end

endmodule

// File: rtl/iir1_inverse_serial.sv
// First-order inverse IIR: x[n] = sat16((G0*y[n] + G1*y[n-1] - H1*x[n-1] + 2^11) >>> 12),
// evaluated over three cycles on one shared 16x16 signed multiplier.
module iir1_inverse_serial
  import iir_pkg::*;
#(
  parameter logic signed [15:0] G0    = 16'sh1000,
  parameter logic signed [15:0] G1    = 16'sh0C00,
  parameter logic signed [15:0] H1    = 16'sh0800,
  parameter int                 ACC_W = 36
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic signed [15:0] Data_IN,
  input  logic               In_Valid,
  output logic               In_Ready,
  output logic signed [15:0] Data_OUT,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  input  logic               Clear_Sat,
  output logic               Sat_Flag
);

  state_t                  r_state;
  state_t                  w_next_state;

  logic signed [15:0]      r_y_cur;
  logic signed [15:0]      r_y1;
  logic signed [15:0]      r_x1;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [15:0]      r_data_out;
  logic                    r_sat_flag;

  logic signed [15:0]      w_coef;
  logic signed [15:0]      w_operand;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_r;
  logic signed [15:0]      w_sat;
  logic                    w_clamp;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept in IDLE, three MAC steps, hold until the consumer takes the result.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (In_Valid) w_next_state = ST_M0;
      ST_M0:   w_next_state = ST_M1;
      ST_M1:   w_next_state = ST_M2;
      ST_M2:   w_next_state = ST_HOLD;
      ST_HOLD: if (Out_Ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only (no path from Out_Ready to In_Ready).
  always_comb begin
    In_Ready  = (r_state == ST_IDLE);
    Out_Valid = (r_state == ST_HOLD);
  end

  // Operand select for the shared multiplier.
  always_comb begin
    w_coef    = G0;
    w_operand = r_y_cur;
    unique case (r_state)
      ST_M1: begin
        w_coef    = G1;
        w_operand = r_y1;
      end
      ST_M2: begin
        w_coef    = H1;
        w_operand = r_x1;
      end
      default: ;
    endcase
  end

  assign w_prod     = 32'(w_coef) * 32'(w_operand);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_r        = r_acc - w_prod_ext;

  sat_round_shift #(
    .ACC_W (ACC_W)
  ) u_sat (
    .i_acc   (w_r),
    .o_data  (w_sat),
    .o_clamp (w_clamp)
  );

  // Datapath: input latch, accumulation, and result/history update in M2.
  always_ff @(posedge CLK) begin
    // NOTE: filter history is reset explicitly so a reset discards both the in-flight sample and the past.
    if (RESET) begin
      r_y_cur    <= '0;
      r_y1       <= '0;
      r_x1       <= '0;
      r_acc      <= '0;
      r_data_out <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (In_Valid) r_y_cur <= Data_IN;
        ST_M0:   r_acc <= w_prod_ext;
        ST_M1:   r_acc <= r_acc + w_prod_ext;
        ST_M2: begin
          r_data_out <= w_sat;
          r_x1       <= w_sat;
          r_y1       <= r_y_cur;
        end
        default: ;
      endcase
    end
  end

  // Sticky saturation flag; a clamp in M2 wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sat_flag <= 1'b0;
    end else if ((r_state == ST_M2) && w_clamp) begin
      r_sat_flag <= 1'b1;
    end else if (Clear_Sat) begin
      r_sat_flag <= 1'b0;
    end
  end

  assign Data_OUT = r_data_out;
  assign Sat_Flag = r_sat_flag;

endmodule

// File: tb/tb_iir1_inverse_serial.sv
// Self-checking bench for iir1_inverse_serial: directed vector table plus handshake corner sequences.
module tb_iir1_inverse_serial;

  logic               CLK = 1'b0;
  logic               RESET;
  logic signed [15:0] Data_IN;
  logic               In_Valid;
  logic               In_Ready;
  logic signed [15:0] Data_OUT;
  logic               Out_Valid;
  logic               Out_Ready;
  logic               Clear_Sat;
  logic               Sat_Flag;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit                 rst_before;
    logic signed [15:0] din;
    logic signed [15:0] exp_out;
    bit                 exp_sat;
  } vec_t;

  vec_t vecs[8];

  always #5 CLK = ~CLK;

  iir1_inverse_serial dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Data_IN   (Data_IN),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Data_OUT  (Data_OUT),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Clear_Sat (Clear_Sat),
    .Sat_Flag  (Sat_Flag)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One-cycle synchronous reset; returns on the negedge after RESET drops.
  task automatic do_reset();
    @(negedge CLK);
    RESET     = 1'b1;
    In_Valid  = 1'b0;
    Clear_Sat = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!Out_Valid && t < 50) begin
      @(negedge CLK);
      t++;
    end
    check({name, " out_valid"}, 32'(Out_Valid), 1);
  endtask

  // Present one sample, wait for its result, and let the Out_Ready=1 handshake complete.
  task automatic run_sample(input logic signed [15:0] din, input string name, output logic signed [15:0] dout);
    int t = 0;
    while (!In_Ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    Data_IN  = din;
    In_Valid = 1'b1;
    @(negedge CLK);
    In_Valid = 1'b0;
    wait_valid(name);
    dout = Data_OUT;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] dout;

    RESET     = 1'b1;
    Data_IN   = '0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    Clear_Sat = 1'b0;

    // Expected values hand-derived from the Q4.12 equation with G0=1.0, G1=0.75, H1=0.5.
    vecs[0] = '{1'b1,   4096,   4096, 1'b0};
    vecs[1] = '{1'b0,      0,   1024, 1'b0};
    vecs[2] = '{1'b0,      0,   -512, 1'b0};
    vecs[3] = '{1'b0,      0,    256, 1'b0};
    vecs[4] = '{1'b1,  32767,  32767, 1'b0};
    vecs[5] = '{1'b0,  32767,  32767, 1'b1};
    vecs[6] = '{1'b1, -32768, -32768, 1'b0};
    vecs[7] = '{1'b0,      0,  -8192, 1'b0};

    do_reset();
    check("rst in_ready",  32'(In_Ready),  1);
    check("rst out_valid", 32'(Out_Valid), 0);
    check("rst data_out",  32'(Data_OUT),  0);
    check("rst sat_flag",  32'(Sat_Flag),  0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_sample(vecs[i].din, $sformatf("vec%0d", i), dout);
      check($sformatf("vec%0d data", i), 32'(dout), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d sat", i), 32'(Sat_Flag), 32'(vecs[i].exp_sat));
    end

    // Latency and handshake timing; busy-time In_Valid with junk data must be ignored.
    do_reset();
    Data_IN  = 4096;
    In_Valid = 1'b1;
    @(negedge CLK);
    Data_IN = 9999;
    check("lat T+0 in_ready",  32'(In_Ready),  0);
    check("lat T+0 out_valid", 32'(Out_Valid), 0);
    @(negedge CLK);
    check("lat T+1 out_valid", 32'(Out_Valid), 0);
    @(negedge CLK);
    check("lat T+2 out_valid", 32'(Out_Valid), 0);
    @(negedge CLK);
    check("lat T+3 out_valid", 32'(Out_Valid), 1);
    check("lat T+3 data",      32'(Data_OUT),  4096);
    check("lat T+3 in_ready",  32'(In_Ready),  0);
    Data_IN = 0;
    @(negedge CLK);
    check("lat T+4 out_valid", 32'(Out_Valid), 0);
    check("lat T+4 in_ready",  32'(In_Ready),  1);
    @(negedge CLK);
    check("lat T+5 in_ready",  32'(In_Ready),  0);
    In_Valid = 1'b0;
    wait_valid("lat second");
    check("lat second data", 32'(Data_OUT), 1024);
    @(negedge CLK);

    // Backpressure: result held for 10 cycles while a new sample waits.
    do_reset();
    Out_Ready = 1'b0;
    Data_IN   = 4096;
    In_Valid  = 1'b1;
    @(negedge CLK);
    Data_IN = 0;
    wait_valid("bp first");
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp stall%0d data", c), 32'(Data_OUT), 4096);
      check($sformatf("bp stall%0d out_valid", c), 32'(Out_Valid), 1);
      check($sformatf("bp stall%0d in_ready", c), 32'(In_Ready), 0);
      @(negedge CLK);
    end
    Out_Ready = 1'b1;
    @(negedge CLK);
    check("bp release out_valid", 32'(Out_Valid), 0);
    check("bp release in_ready",  32'(In_Ready),  1);
    @(negedge CLK);
    check("bp accept in_ready", 32'(In_Ready), 0);
    In_Valid = 1'b0;
    wait_valid("bp second");
    check("bp second data", 32'(Data_OUT), 1024);
    @(negedge CLK);

    // Sticky saturation flag, clear pulse, and clamp winning over a simultaneous clear.
    do_reset();
    run_sample(16'sd32767, "sat a", dout);
    check("sat a data", 32'(dout), 32767);
    check("sat a flag", 32'(Sat_Flag), 0);
    run_sample(16'sd32767, "sat b", dout);
    check("sat b data", 32'(dout), 32767);
    repeat (3) @(negedge CLK);
    check("sat sticky", 32'(Sat_Flag), 1);
    Clear_Sat = 1'b1;
    @(negedge CLK);
    Clear_Sat = 1'b0;
    check("sat cleared", 32'(Sat_Flag), 0);
    Data_IN  = 32767;
    In_Valid = 1'b1;
    @(negedge CLK);
    In_Valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Clear_Sat = 1'b1;
    @(negedge CLK);
    Clear_Sat = 1'b0;
    check("sat clamp+clear out_valid", 32'(Out_Valid), 1);
    check("sat clamp+clear data", 32'(Data_OUT), 32767);
    check("sat clamp+clear flag", 32'(Sat_Flag), 1);
    @(negedge CLK);

    // Reset while the MAC sequence is in M1 discards the sample and the history.
    Data_IN  = 4096;
    In_Valid = 1'b1;
    @(negedge CLK);
    In_Valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst out_valid", 32'(Out_Valid), 0);
    check("midrst data",      32'(Data_OUT),  0);
    check("midrst in_ready",  32'(In_Ready),  1);
    check("midrst sat_flag",  32'(Sat_Flag),  0);
    repeat (5) @(negedge CLK);
    check("midrst discarded", 32'(Out_Valid), 0);
    run_sample(16'sd4096, "midrst imp0", dout);
    check("midrst imp0 data", 32'(dout), 4096);
    run_sample(16'sd0, "midrst imp1", dout);
    check("midrst imp1 data", 32'(dout), 1024);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
